// File: rtl/dt_stage.sv
// ---------------------------------------------------------------------------
// dt_stage
//
// Pipeline stage that follows the data-TLB stage. It registers the DTLB-stage
// buses under the common flush/stall rules and captures the synchronous
// data-SRAM read data. Read data is on data_sram_rdata for one cycle only, so
// the stage keeps a copy in rbuf while it is held. Load results are then
// byte/halfword aligned and sign/zero extended.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous, active-high reset
//   flush                kills the stage contents
//   stall                stall bus; [5] stops this stage, [6] stops the next
//   dtlb_to_dt_bus       [31:0] ex_result/address, [36:32] wb_addr, [37] wb_en,
//                        [40:38] load_op, [41] valid, upper bits passed through
//   dtlb_to_dt_sram_bus  {en[69], wen[68], sel[67:64], addr[63:32], wdata[31:0]}
//   data_sram_rdata      SRAM read data, valid one cycle after the request
//   dt_to_mem_bus        registered bus with [31:0] replaced by the result
//   dt_to_id_bus         {wb_en & valid, wb_addr[4:0], result[31:0]} forwarding
// ---------------------------------------------------------------------------
module dt_stage #(
    parameter int DTLB_TO_DT_WD = 42,
    parameter int IN_WD         = DTLB_TO_DT_WD,
    parameter int DATA_SRAM_WD  = 70,
    parameter int SRAM_WD       = DATA_SRAM_WD,
    parameter int STALL_WD      = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [STALL_WD-1:0] stall,
    input  logic [IN_WD-1:0]    dtlb_to_dt_bus,
    input  logic [SRAM_WD-1:0]  dtlb_to_dt_sram_bus,
    input  logic [31:0]         data_sram_rdata,
    output logic [IN_WD-1:0]    dt_to_mem_bus,
    output logic [37:0]         dt_to_id_bus
);

    // Stall bus encoding and field positions.
    localparam logic STOP = 1'b1;

    localparam int BUS_VALID   = 41;
    localparam int BUS_OP_HI   = 40;
    localparam int BUS_OP_LO   = 38;
    localparam int BUS_WB_EN   = 37;
    localparam int BUS_WB_A_HI = 36;
    localparam int BUS_WB_A_LO = 32;

    localparam int SRAM_EN     = 69;
    localparam int SRAM_WEN    = 68;
    localparam int SRAM_ADDR   = 32;

    // What the stage registers do on the next edge, in precedence order.
    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_LOAD,
        UPD_BUBBLE,
        UPD_FLUSH
    } upd_e;

    typedef enum logic [2:0] {
        LOP_NONE = 3'd0,
        LOP_LB   = 3'd1,
        LOP_LBU  = 3'd2,
        LOP_LH   = 3'd3,
        LOP_LHU  = 3'd4,
        LOP_LW   = 3'd5
    } load_op_e;

    logic [IN_WD-1:0]   bus_r;
    logic [SRAM_WD-1:0] sram_r;
    logic               fresh;
    logic [31:0]        rbuf;
    logic               rbuf_v;

    upd_e               upd;
    logic               stop_self;
    logic               stop_next;
    logic               in_is_read;

    logic [31:0]        rd;
    logic [1:0]         byte_off;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [2:0]         load_op;
    logic [31:0]        result;

    assign stop_self  = (stall[5] == STOP);
    assign stop_next  = (stall[6] == STOP);
    assign in_is_read = dtlb_to_dt_sram_bus[SRAM_EN] & ~dtlb_to_dt_sram_bus[SRAM_WEN];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        upd = UPD_HOLD;
        if (flush) begin
            upd = UPD_FLUSH;
        end else if (stop_self && !stop_next) begin
            upd = UPD_BUBBLE;
        end else if (!stop_self) begin
            upd = UPD_LOAD;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_r  <= '0;
            sram_r <= '0;
            fresh  <= 1'b0;
            // NOTE: rbuf is a single 32-bit register, not an array, so it is
            // reset with the rest; no held load survives a reset.
            rbuf   <= '0;
            rbuf_v <= 1'b0;
        end else begin
            case (upd)
                UPD_FLUSH, UPD_BUBBLE: begin
                    bus_r  <= '0;
                    sram_r <= '0;
                end
                UPD_LOAD: begin
                    bus_r  <= dtlb_to_dt_bus;
                    sram_r <= dtlb_to_dt_sram_bus;
                end
                default: begin
                    bus_r  <= bus_r;
                    sram_r <= sram_r;
                end
            endcase

            // fresh marks the one cycle in which the SRAM answers this load.
            fresh <= (upd == UPD_LOAD) && in_is_read;

            // Any change of stage contents invalidates the buffer; a flush in
            // the capture cycle therefore wins over the capture.
            if (upd != UPD_HOLD) begin
                rbuf_v <= 1'b0;
            end else if (fresh && stop_self && stop_next) begin
                rbuf   <= data_sram_rdata;
                rbuf_v <= 1'b1;
            end
        end
    end

    // Live read data in the fresh cycle, buffered copy while held afterwards.
    assign rd       = rbuf_v ? rbuf : data_sram_rdata;
    assign byte_off = sram_r[SRAM_ADDR +: 2];
    assign rd_byte  = rd[8*byte_off +: 8];
    assign rd_half  = byte_off[1] ? rd[31:16] : rd[15:0];
    assign load_op  = bus_r[BUS_OP_HI:BUS_OP_LO];

    always_comb begin
        result = bus_r[31:0];
        case (load_op)
            LOP_LB:  result = {{24{rd_byte[7]}}, rd_byte};
            LOP_LBU: result = {24'd0, rd_byte};
            LOP_LH:  result = {{16{rd_half[15]}}, rd_half};
            LOP_LHU: result = {16'd0, rd_half};
            LOP_LW:  result = rd;
            default: result = bus_r[31:0];
        endcase
    end

    assign dt_to_mem_bus = {bus_r[IN_WD-1:32], result};
    assign dt_to_id_bus  = {bus_r[BUS_WB_EN] & bus_r[BUS_VALID],
                            bus_r[BUS_WB_A_HI:BUS_WB_A_LO], result};

    // Fields of the SRAM request that this stage carries but does not consume.
    logic unused_ok;
    assign unused_ok = ^{sram_r, stall};

endmodule

// File: tb/tb_dt_stage.sv
module tb_dt_stage;

    localparam int IN_WD    = 48;
    localparam int SRAM_WD  = 70;
    localparam int STALL_WD = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [STALL_WD-1:0] stall;
    logic [IN_WD-1:0]    dtlb_to_dt_bus;
    logic [SRAM_WD-1:0]  dtlb_to_dt_sram_bus;
    logic [31:0]         data_sram_rdata;
    logic [IN_WD-1:0]    dt_to_mem_bus;
    logic [37:0]         dt_to_id_bus;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dt_stage #(
        .DTLB_TO_DT_WD(IN_WD),
        .IN_WD        (IN_WD),
        .DATA_SRAM_WD (SRAM_WD),
        .SRAM_WD      (SRAM_WD),
        .STALL_WD     (STALL_WD)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .stall              (stall),
        .dtlb_to_dt_bus     (dtlb_to_dt_bus),
        .dtlb_to_dt_sram_bus(dtlb_to_dt_sram_bus),
        .data_sram_rdata    (data_sram_rdata),
        .dt_to_mem_bus      (dt_to_mem_bus),
        .dt_to_id_bus       (dt_to_id_bus)
    );

    // ---------------- reference model ----------------
    // The stage holds one instruction. A load sees whatever the SRAM returns
    // during its first cycle in the stage and keeps seeing that value for as
    // long as it stays; anything else sees the live read data.
    logic [IN_WD-1:0]   m_bus;
    logic [SRAM_WD-1:0] m_sram;
    logic               m_first;
    logic               m_read;
    logic [31:0]        m_cap;

    task automatic model_reset();
        m_bus   = '0;
        m_sram  = '0;
        m_first = 1'b0;
        m_read  = 1'b0;
        m_cap   = '0;
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdv, input logic [31:0] ex);
        logic [31:0] bv, hv;
        bv = (rdv >> (8 * addr[1:0])) & 32'hFF;
        hv = (rdv >> (16 * addr[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (bv ^ 32'h80) - 32'h80;
            3'd2:    return bv;
            3'd3:    return (hv ^ 32'h8000) - 32'h8000;
            3'd4:    return hv;
            3'd5:    return rdv;
            default: return ex;
        endcase
    endfunction

    task automatic model_check();
        logic [31:0]      rdv, res;
        logic [IN_WD-1:0] exp_mem;
        logic [37:0]      exp_id;
        rdv     = (m_read && !m_first) ? m_cap : data_sram_rdata;
        res     = ref_result(m_bus[40:38], m_sram[63:32], rdv, m_bus[31:0]);
        exp_mem = {m_bus[IN_WD-1:32], res};
        exp_id  = {m_bus[37] & m_bus[41], m_bus[36:32], res};
        check("mem_bus", 64'(dt_to_mem_bus), 64'(exp_mem));
        check("id_bus", 64'(dt_to_id_bus), 64'(exp_id));
    endtask

    task automatic model_update();
        if (flush || (stall[5] && !stall[6])) begin
            model_reset();
        end else if (!stall[5]) begin
            m_bus   = dtlb_to_dt_bus;
            m_sram  = dtlb_to_dt_sram_bus;
            m_first = 1'b1;
            m_read  = dtlb_to_dt_sram_bus[69] & ~dtlb_to_dt_sram_bus[68];
        end else begin
            if (m_first) m_cap = data_sram_rdata;
            m_first = 1'b0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [IN_WD-1:0] mk_bus(input logic valid, input logic wb_en,
                                                input logic [4:0] wb_addr, input logic [2:0] op,
                                                input logic [31:0] ex, input logic [5:0] up);
        return {up, valid, op, wb_en, wb_addr, ex};
    endfunction

    function automatic logic [SRAM_WD-1:0] mk_sram(input logic en, input logic wen,
                                                   input logic [31:0] addr);
        return {en, wen, 4'hF, addr, 32'h0};
    endfunction

    // Drive one cycle's inputs at the falling edge, then compare against the model.
    task automatic drive(input logic f, input logic [1:0] st, input logic [IN_WD-1:0] b,
                         input logic [SRAM_WD-1:0] s, input logic [31:0] rdv);
        @(negedge clk);
        flush               = f;
        stall               = {st, 5'($urandom)};
        dtlb_to_dt_bus      = b;
        dtlb_to_dt_sram_bus = s;
        data_sram_rdata     = rdv;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic cyc(input logic f, input logic [1:0] st, input logic [IN_WD-1:0] b,
                       input logic [SRAM_WD-1:0] s, input logic [31:0] rdv);
        drive(f, st, b, s, rdv);
        tick();
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    localparam logic [IN_WD-1:0]   NB = '0;
    localparam logic [SRAM_WD-1:0] NS = '0;

    initial begin
        vecs[0]  = '{3'd1, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80};
        vecs[1]  = '{3'd2, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080};
        vecs[2]  = '{3'd3, 32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_80FF};
        vecs[3]  = '{3'd4, 32'h0000_1002, 32'h80FF_7F01, 32'h0000_80FF};
        vecs[4]  = '{3'd1, 32'h0000_2000, 32'h80FF_7F01, 32'h0000_0001};
        vecs[5]  = '{3'd1, 32'h0000_2001, 32'h80FF_7F01, 32'h0000_007F};
        vecs[6]  = '{3'd2, 32'h0000_2002, 32'h80FF_7F01, 32'h0000_00FF};
        vecs[7]  = '{3'd1, 32'h0000_2002, 32'h80FF_7F01, 32'hFFFF_FFFF};
        vecs[8]  = '{3'd3, 32'h0000_3000, 32'h80FF_7F01, 32'h0000_7F01};
        vecs[9]  = '{3'd5, 32'h0000_3004, 32'h80FF_7F01, 32'h80FF_7F01};
        vecs[10] = '{3'd6, 32'h0000_0100, 32'h5555_AAAA, 32'h0000_0100};
        vecs[11] = '{3'd7, 32'h0000_0204, 32'h5555_AAAA, 32'h0000_0204};
        vecs[12] = '{3'd0, 32'h0000_0308, 32'h5555_AAAA, 32'h0000_0308};

        rst                 = 1'b1;
        flush               = 1'b0;
        stall               = '0;
        dtlb_to_dt_bus      = '0;
        dtlb_to_dt_sram_bus = '0;
        data_sram_rdata     = '0;
        model_reset();

        // 1. Reset state and a plain ALU result.
        #12;
        check("reset_mem", 64'(dt_to_mem_bus), 64'h0);
        check("reset_id", 64'(dt_to_id_bus), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 2'b00, mk_bus(1'b1, 1'b1, 5'd5, 3'd0, 32'h1234, 6'h0), NS, 32'h0);
        drive(1'b0, 2'b00, NB, NS, 32'hFFFF_FFFF);
        check("alu_id", 64'(dt_to_id_bus), 64'({1'b1, 5'd5, 32'h0000_1234}));
        tick();

        // 2. Table of load formatting vectors.
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, 2'b00, mk_bus(1'b1, 1'b1, 5'd3, vecs[i].op, vecs[i].addr, 6'h2A),
                mk_sram(1'b1, vecs[i].op == 3'd0, vecs[i].addr), $urandom);
            drive(1'b0, 2'b00, NB, NS, vecs[i].rdata);
            check($sformatf("vec%0d", i), 64'(dt_to_mem_bus[31:0]), 64'(vecs[i].exp));
            tick();
        end

        // 3. lw held for 3 extra cycles while rdata goes to 0.
        cyc(1'b0, 2'b00, mk_bus(1'b1, 1'b1, 5'd7, 3'd5, 32'h40, 6'h0), mk_sram(1'b1, 1'b0, 32'h40), 32'h0);
        drive(1'b0, 2'b11, NB, NS, 32'hDEAD_BEEF);
        check("hold_c0", 64'(dt_to_mem_bus[31:0]), 64'hDEAD_BEEF);
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 2'b11, NB, NS, 32'h0);
            check($sformatf("hold_c%0d", i), 64'(dt_to_mem_bus[31:0]), 64'hDEAD_BEEF);
            tick();
        end

        // 4. Bubble, then a new load must use live data.
        drive(1'b0, 2'b01, NB, NS, 32'h0);
        check("pre_bubble", 64'(dt_to_mem_bus[31:0]), 64'hDEAD_BEEF);
        tick();
        drive(1'b0, 2'b00, mk_bus(1'b1, 1'b1, 5'd9, 3'd5, 32'h80, 6'h0), mk_sram(1'b1, 1'b0, 32'h80), 32'h1111_1111);
        check("bubble_mem", 64'(dt_to_mem_bus), 64'h0);
        check("bubble_id", 64'(dt_to_id_bus), 64'h0);
        tick();
        drive(1'b0, 2'b11, NB, NS, 32'hCAFE_F00D);
        check("after_bubble", 64'(dt_to_mem_bus[31:0]), 64'hCAFE_F00D);
        tick();

        // 5. Flush in the fresh cycle wins over the capture.
        cyc(1'b0, 2'b00, mk_bus(1'b1, 1'b1, 5'd4, 3'd5, 32'hC0, 6'h0), mk_sram(1'b1, 1'b0, 32'hC0), 32'h0);
        drive(1'b1, 2'b11, NB, NS, 32'hAAAA_5555);
        check("flush_fresh", 64'(dt_to_mem_bus[31:0]), 64'hAAAA_5555);
        tick();
        drive(1'b0, 2'b00, mk_bus(1'b1, 1'b1, 5'd6, 3'd5, 32'hD0, 6'h0), mk_sram(1'b1, 1'b0, 32'hD0), 32'h1234_5678);
        check("flush_mem", 64'(dt_to_mem_bus), 64'h0);
        check("flush_id", 64'(dt_to_id_bus), 64'h0);
        tick();
        drive(1'b0, 2'b00, mk_bus(1'b1, 1'b1, 5'd8, 3'd5, 32'hE4, 6'h0), mk_sram(1'b1, 1'b0, 32'hE4), 32'h0000_0001);
        check("after_flush", 64'(dt_to_mem_bus[31:0]), 64'h0000_0001);
        tick();

        // Back-to-back loads: second fresh cycle uses live data, then holds it.
        drive(1'b0, 2'b11, NB, NS, 32'h0000_0002);
        check("b2b_fresh", 64'(dt_to_mem_bus[31:0]), 64'h0000_0002);
        tick();
        drive(1'b0, 2'b11, NB, NS, 32'h0);
        check("b2b_hold", 64'(dt_to_mem_bus[31:0]), 64'h0000_0002);
        tick();

        // Store held: never buffered, always live.
        cyc(1'b0, 2'b00, mk_bus(1'b1, 1'b0, 5'd0, 3'd5, 32'h10, 6'h0), mk_sram(1'b1, 1'b1, 32'h10), 32'h0);
        cyc(1'b0, 2'b11, NB, NS, 32'h7777_7777);
        drive(1'b0, 2'b11, NB, NS, 32'h3333_3333);
        check("store_live", 64'(dt_to_mem_bus[31:0]), 64'h3333_3333);
        tick();

        // 6. Asynchronous reset in the middle of a buffered lw hold.
        cyc(1'b0, 2'b00, mk_bus(1'b1, 1'b1, 5'd2, 3'd5, 32'h20, 6'h3F), mk_sram(1'b1, 1'b0, 32'h20), 32'h0);
        cyc(1'b0, 2'b11, NB, NS, 32'h0BAD_F00D);
        drive(1'b0, 2'b11, NB, NS, 32'h0);
        check("pre_reset", 64'(dt_to_mem_bus[31:0]), 64'h0BAD_F00D);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_mem", 64'(dt_to_mem_bus), 64'h0);
        check("async_rst_id", 64'(dt_to_id_bus), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] addr;
            op   = 3'($urandom);
            addr = $urandom;
            cyc(($urandom % 16) == 0, 2'($urandom),
                mk_bus(1'($urandom), 1'($urandom), 5'($urandom), op, $urandom, 6'($urandom)),
                mk_sram(($urandom % 4) != 0, ($urandom % 3) == 0, addr), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
